// File: rtl/imem_boot_loader.sv
// Boot loader for the single-cycle MIPS core. It turns a counted byte stream
// into big-endian instruction words and holds the core in reset until the XOR checksum matches.
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_WORDS  = 256
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   input  logic                  load_req,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           words_loaded,
   output logic [2:0]            dbg_state
);

   localparam int          IDX_W    = $clog2(MAX_WORDS + 1);
   localparam logic [31:0] MAX_W32  = 32'(MAX_WORDS);

   typedef enum logic [2:0] {
      HDR_HI  = 3'd0,
      HDR_LO  = 3'd1,
      PAYLOAD = 3'd2,
      CHECK   = 3'd3,
      DONE    = 3'd4,
      ERROR   = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [15:0]             count_q, count_d;
   logic [1:0]              bcnt_q, bcnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [23:0]             asm_q, asm_d;
   logic [7:0]              chk_q, chk_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [15:0]             words_q, words_d;

   logic        byte_fire;
   logic [15:0] hdr_n;

   // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
   // byte_ready depends only on state, never on byte_valid.
   assign byte_ready = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                       (state_q == PAYLOAD) || (state_q == CHECK);
   assign byte_fire  = byte_valid && byte_ready;
   assign hdr_n      = {count_q[15:8], byte_in};

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      bcnt_d  = bcnt_q;
      idx_d   = idx_q;
      asm_d   = asm_q;
      chk_d   = chk_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      words_d = words_q;

      case (state_q)
         HDR_HI: begin
            if (byte_fire) begin
               count_d = {byte_in, 8'h00};
               state_d = HDR_LO;
            end
         end
         HDR_LO: begin
            if (byte_fire) begin
               count_d = hdr_n;
               if ((hdr_n == 16'd0) || ({16'd0, hdr_n} > MAX_W32)) begin
                  state_d = ERROR;
               end else begin
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (byte_fire) begin
               chk_d  = chk_q ^ byte_in;
               asm_d  = {asm_q[15:0], byte_in};
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  // The write pulse is registered, so it overlaps the next byte.
                  we_d    = 1'b1;
                  addr_d  = ADDR_WIDTH'({idx_q, 2'b00});
                  wdata_d = {asm_q, byte_in};
                  idx_d   = idx_q + IDX_W'(1);
                  words_d = words_q + 16'd1;
                  if ((16'(idx_q) + 16'd1) == count_q) begin
                     state_d = CHECK;
                  end
               end
            end
         end
         CHECK: begin
            if (byte_fire) begin
               state_d = (byte_in == chk_q) ? DONE : ERROR;
            end
         end
         DONE, ERROR: begin
            if (load_req) begin
               state_d = HDR_HI;
               count_d = 16'd0;
               bcnt_d  = 2'd0;
               idx_d   = '0;
               asm_d   = 24'd0;
               chk_d   = 8'd0;
               words_d = 16'd0;
            end
         end
         default: state_d = HDR_HI;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= HDR_HI;
         count_q <= 16'd0;
         bcnt_q  <= 2'd0;
         idx_q   <= '0;
         asm_q   <= 24'd0;
         chk_q   <= 8'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         words_q <= 16'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bcnt_q  <= bcnt_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         chk_q   <= chk_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         words_q <= words_d;
      end
   end

   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign words_loaded = words_q;
   assign done         = (state_q == DONE);
   assign error        = (state_q == ERROR);
   assign cpu_reset    = (state_q != DONE);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: drives byte streams and checks every
// write pulse against an expected queue plus status outputs at key points.
module tb_imem_boot_loader;

   localparam int W = 80;

   logic        clock;
   logic        reset;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        load_req;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;
   logic [2:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   // Each expected write is {words_loaded, imem_addr, imem_wdata}.
   logic [W-1:0] exp_q[$];

   logic [7:0] img[11];

   imem_boot_loader #(.ADDR_WIDTH(32), .MAX_WORDS(256)) dut (
      .clock        (clock),
      .reset        (reset),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .load_req     (load_req),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_reset    (cpu_reset),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded),
      .dbg_state    (dbg_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Write monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("extra_we", W'({words_loaded, imem_addr, imem_wdata}), W'(0));
         end else begin
            check("write", W'({words_loaded, imem_addr, imem_wdata}), exp_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic lreq);
      byte_valid = 1'b1;
      byte_in    = b;
      load_req   = lreq;
      @(posedge clock);
      #1;
      byte_valid = 1'b0;
      load_req   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse_load_req();
      load_req = 1'b1;
      @(posedge clock);
      #1 load_req = 1'b0;
   endtask

   // Sends the reference image with the given checksum byte; max_gap>0 adds
   // random idle cycles, lreq_at marks the byte that carries a load_req pulse.
   task automatic send_image(input logic [7:0] chk, input int max_gap, input int lreq_at);
      for (int i = 0; i < 11; i++) begin
         send_byte((i == 10) ? chk : img[i], i == lreq_at);
         if (max_gap > 0 && i < 10) idle($urandom_range(max_gap, 1));
      end
   endtask

   task automatic expect_image_writes();
      exp_q.push_back({16'd1, 32'h0000_0000, 32'h2008_0005});
      exp_q.push_back({16'd2, 32'h0000_0004, 32'h0108_4020});
   endtask

   task automatic check_status(input string tag, input logic exp_done, input logic exp_err,
                               input logic exp_rdy, input logic [15:0] exp_words);
      @(negedge clock);
      check({tag, "_done"},  W'(done),         W'(exp_done));
      check({tag, "_error"}, W'(error),        W'(exp_err));
      check({tag, "_cpurst"}, W'(cpu_reset),   W'(!exp_done));
      check({tag, "_ready"}, W'(byte_ready),   W'(exp_rdy));
      check({tag, "_words"}, W'(words_loaded), W'(exp_words));
      @(posedge clock);
      #1;
   endtask

   initial begin
      img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08, 8'h40, 8'h20, 8'h44};
      reset      = 1'b1;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      load_req   = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state.
      @(negedge clock);
      check("rst_we",    W'(imem_we),    W'(0));
      check("rst_addr",  W'(imem_addr),  W'(0));
      check("rst_wdata", W'(imem_wdata), W'(0));
      @(posedge clock);
      #1;
      check_status("rst", 1'b0, 1'b0, 1'b1, 16'd0);

      // Valid image, back-to-back.
      expect_image_writes();
      send_image(8'h44, 0, -1);
      check_status("s1", 1'b1, 1'b0, 1'b0, 16'd2);
      check("s1_pending", W'(exp_q.size()), W'(0));

      // load_req in DONE.
      pulse_load_req();
      check_status("s7", 1'b0, 1'b0, 1'b1, 16'd0);

      // Bad checksum.
      expect_image_writes();
      send_image(8'h45, 0, -1);
      check_status("s2", 1'b0, 1'b1, 1'b0, 16'd2);
      check("s2_pending", W'(exp_q.size()), W'(0));

      // Zero word count.
      pulse_load_req();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      check_status("s3", 1'b0, 1'b1, 1'b0, 16'd0);

      // Word count of 257 exceeds the memory.
      pulse_load_req();
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      check_status("s4", 1'b0, 1'b1, 1'b0, 16'd0);

      // Same image with idle gaps between bytes.
      pulse_load_req();
      expect_image_writes();
      send_image(8'h44, 3, -1);
      check_status("s5", 1'b1, 1'b0, 1'b0, 16'd2);
      check("s5_pending", W'(exp_q.size()), W'(0));

      // Reset after 5 payload bytes, then a full load.
      pulse_load_req();
      exp_q.push_back({16'd1, 32'h0000_0000, 32'h2008_0005});
      for (int i = 0; i < 7; i++) send_byte(img[i], 1'b0);
      idle(2);
      check("s6_pre_pending", W'(exp_q.size()), W'(0));
      do_reset();
      check_status("s6_rst", 1'b0, 1'b0, 1'b1, 16'd0);
      expect_image_writes();
      send_image(8'h44, 0, -1);
      check_status("s6", 1'b1, 1'b0, 1'b0, 16'd2);
      check("s6_pending", W'(exp_q.size()), W'(0));

      // load_req during PAYLOAD is ignored.
      pulse_load_req();
      expect_image_writes();
      send_image(8'h44, 0, 4);
      check_status("s8", 1'b1, 1'b0, 1'b0, 16'd2);
      check("s8_pending", W'(exp_q.size()), W'(0));

      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1);
   end

endmodule
